// File: rtl/mips_mem_defs.sv
// rtl/mips_mem_defs.sv - shared data-memory widths and store-entry layout
package mips_mem_defs;
  localparam int MM_ADDR_W = 8;
  localparam int MM_DATA_W = 32;
  localparam int DM_DEPTH  = 256;

  typedef struct packed {
    logic [MM_ADDR_W-1:0] addr;
    logic [MM_DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - single-ported data memory bus
interface store_buffer_if
  import mips_mem_defs::*;
#(
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W
);
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_write;
  logic [DATA_W-1:0] dm_rdata;

  modport master (output dm_addr, output dm_wdata, output dm_write, input dm_rdata);
  modport slave  (input dm_addr, input dm_wdata, input dm_write, output dm_rdata);
endinterface

// File: rtl/store_buffer_fwd_match.sv
// rtl/store_buffer_fwd_match.sv - youngest-match search over buffered store addresses
module sb_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic [ADDR_W-1:0] ent_addr [DEPTH],
  input  logic [PTR_W-1:0]  rd_ptr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] key,
  output logic              hit,
  output logic [PTR_W-1:0]  idx
);
  // Walk from oldest to youngest; a later match overwrites, so the youngest wins.
  always_comb begin
    hit = 1'b0;
    idx = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (ent_addr[rd_ptr + PTR_W'(k)] == key)) begin
        hit = 1'b1;
        idx = rd_ptr + PTR_W'(k);
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store FIFO between MEM stage and data memory with load forwarding
module store_buffer
  import mips_mem_defs::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = MM_ADDR_W,
  parameter int DATA_W = MM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       MEM_alu_out,
  input  logic [DATA_W-1:0] MEM_rd2,
  input  logic              MEM_read,
  input  logic              MEM_write,
  output logic [DATA_W-1:0] MEM_rdata,
  output logic              MEM_stall,
  output logic              sb_empty,
  store_buffer_if.master    dm
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [ADDR_W-1:0] ent_addr_d [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] ld_addr;
  logic              full, drain, enq, hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              unused_addr_hi;

  assign ld_addr        = MEM_alu_out[ADDR_W-1:0];
  assign unused_addr_hi = ^MEM_alu_out[31:ADDR_W];

  // Loads own the port; drain only in cycles without a load.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign drain     = !MEM_read && (count_q != '0);
  assign enq       = MEM_write && !full;
  assign MEM_stall = MEM_write && full;
  assign sb_empty  = (count_q == '0);

  assign dm.dm_write = drain;
  assign dm.dm_addr  = drain ? ent_addr_q[rd_ptr_q] : ld_addr;
  assign dm.dm_wdata = ent_data_q[rd_ptr_q];

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_fwd (
    .ent_addr (ent_addr_q),
    .rd_ptr   (rd_ptr_q),
    .count    (count_q),
    .key      (ld_addr),
    .hit      (hit),
    .idx      (hit_idx)
  );

  assign MEM_rdata = hit ? ent_data_q[hit_idx] : dm.dm_rdata;

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CNT_W'(enq) - CNT_W'(drain);
    if (enq) begin
      ent_addr_d[wr_ptr_q] = ld_addr;
      ent_data_d[wr_ptr_q] = MEM_rd2;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (drain) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payloads are qualified by count, so they need no reset.
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed bench for store_buffer with a queue-based reference model
module tb_store_buffer;
  import mips_mem_defs::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] MEM_alu_out;
  logic [31:0] MEM_rd2;
  logic        MEM_read;
  logic        MEM_write;
  logic [31:0] MEM_rdata;
  logic        MEM_stall;
  logic        sb_empty;

  store_buffer_if dm_if ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MEM_alu_out (MEM_alu_out),
    .MEM_rd2     (MEM_rd2),
    .MEM_read    (MEM_read),
    .MEM_write   (MEM_write),
    .MEM_rdata   (MEM_rdata),
    .MEM_stall   (MEM_stall),
    .sb_empty    (sb_empty),
    .dm          (dm_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  // Data memory: untouched words read back as init_val.
  logic [31:0] mem   [DM_DEPTH];
  bit          mem_v [DM_DEPTH];
  logic [39:0] wr_log [$];

  assign dm_if.dm_rdata = mem_v[dm_if.dm_addr] ? mem[dm_if.dm_addr] : init_val(dm_if.dm_addr);

  always @(posedge clk) begin
    if (dm_if.dm_write) begin
      mem[dm_if.dm_addr]   <= dm_if.dm_wdata;
      mem_v[dm_if.dm_addr] <= 1'b1;
      wr_log.push_back({dm_if.dm_addr, dm_if.dm_wdata});
    end
  end

  // Reference model: program-order queue of pending stores plus expected memory image.
  sb_entry_t   mq [$];
  logic [31:0] ref_mem [DM_DEPTH];
  bit          ref_v   [DM_DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] ref_read(input logic [7:0] a);
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].addr == a) return mq[i].data;
    return ref_v[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic       exp_drain;
    logic [7:0] a;
    a         = MEM_alu_out[7:0];
    exp_drain = !MEM_read && (mq.size() > 0);
    chk("dm_write", {31'h0, dm_if.dm_write}, {31'h0, exp_drain});
    chk("dm_addr", {24'h0, dm_if.dm_addr}, {24'h0, exp_drain ? mq[0].addr : a});
    if (exp_drain) chk("dm_wdata", dm_if.dm_wdata, mq[0].data);
    chk("stall", {31'h0, MEM_stall}, {31'h0, MEM_write && (mq.size() == DEPTH)});
    chk("sb_empty", {31'h0, sb_empty}, {31'h0, mq.size() == 0});
    if (MEM_read) chk("rdata", MEM_rdata, ref_read(a));
  endtask

  task automatic model_step();
    bit full;
    full = (mq.size() == DEPTH);
    if (!MEM_read && mq.size() > 0) begin
      ref_mem[mq[0].addr] = mq[0].data;
      ref_v[mq[0].addr]   = 1'b1;
      void'(mq.pop_front());
    end
    if (MEM_write && !full) mq.push_back('{addr: MEM_alu_out[7:0], data: MEM_rd2});
  endtask

  // Inputs change just after posedge; outputs are checked just after negedge.
  task automatic drive(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d);
    MEM_read    = rd;
    MEM_write   = wr;
    MEM_alu_out = {24'hA5A5A5, a};
    MEM_rd2     = d;
    @(negedge clk);
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d);
    drive(rd, wr, a, d);
    tick();
  endtask

  int base;
  int bad_mem;
  logic [7:0] fill_addr [4];

  initial begin
    rst_n = 1'b0;
    MEM_read = 1'b0;
    MEM_write = 1'b0;
    MEM_alu_out = '0;
    MEM_rd2 = '0;
    fill_addr[0] = 8'h21; fill_addr[1] = 8'h22; fill_addr[2] = 8'h23; fill_addr[3] = 8'h25;
    #12;
    chk("rst_sb_empty", {31'h0, sb_empty}, 32'h1);
    chk("rst_dm_write", {31'h0, dm_if.dm_write}, 32'h0);
    chk("rst_stall", {31'h0, MEM_stall}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single store, then drain
    cyc(0, 1, 8'h10, 32'hDEADBEEF);
    drive(0, 0, 8'h00, 32'h0);
    chk("t1_dm_write", {31'h0, dm_if.dm_write}, 32'h1);
    chk("t1_dm_addr", {24'h0, dm_if.dm_addr}, 32'h10);
    chk("t1_dm_wdata", dm_if.dm_wdata, 32'hDEADBEEF);
    tick();
    drive(0, 0, 8'h00, 32'h0);
    chk("t1_empty", {31'h0, sb_empty}, 32'h1);
    tick();

    // Load right after a store forwards from the buffer
    cyc(0, 1, 8'h05, 32'h11111111);
    drive(1, 0, 8'h05, 32'h0);
    chk("t2_fwd", MEM_rdata, 32'h11111111);
    chk("t2_dm_write", {31'h0, dm_if.dm_write}, 32'h0);
    tick();
    cyc(0, 0, 8'h00, 32'h0);

    // Youngest of two same-address stores wins; memory sees both in order
    base = wr_log.size();
    cyc(1, 1, 8'h07, 32'hA);
    cyc(1, 1, 8'h07, 32'hB);
    drive(1, 0, 8'h07, 32'h0);
    chk("t3_youngest", MEM_rdata, 32'hB);
    tick();
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 32'h0);
    chk("t3_log_n", wr_log.size() - base, 2);
    chk("t3_log0", wr_log[base][31:0], 32'hA);
    chk("t3_log1", wr_log[base+1][31:0], 32'hB);

    // Fill under held loads, fifth store stalls until a drain frees a slot
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'h20 + 8'(i), 32'h100 + i);
    drive(1, 1, 8'h24, 32'h104);
    chk("t4_stall_full", {31'h0, MEM_stall}, 32'h1);
    tick();
    drive(0, 1, 8'h24, 32'h104);
    chk("t4_stall_drain", {31'h0, MEM_stall}, 32'h1);
    chk("t4_drain_addr", {24'h0, dm_if.dm_addr}, 32'h20);
    tick();
    drive(0, 1, 8'h24, 32'h104);
    chk("t4_stall_clear", {31'h0, MEM_stall}, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 32'h0);

    // Reset in the middle of a drain discards everything
    for (int i = 0; i < 4; i++) cyc(1, 1, fill_addr[i], 32'h55000000 + i);
    drive(0, 0, 8'h00, 32'h0);
    chk("t5_pre_drain", {31'h0, dm_if.dm_write}, 32'h1);
    #2;
    rst_n = 1'b0;
    mq.delete();
    MEM_read = 1'b1;
    MEM_write = 1'b1;
    MEM_alu_out = {24'hA5A5A5, 8'h21};
    #1;
    chk("t5_dm_write", {31'h0, dm_if.dm_write}, 32'h0);
    chk("t5_empty", {31'h0, sb_empty}, 32'h1);
    chk("t5_stall", {31'h0, MEM_stall}, 32'h0);
    chk("t5_rdata", MEM_rdata, 32'h101);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    MEM_read = 1'b0;
    MEM_write = 1'b0;

    // Back-to-back stores with concurrent drains wrap the pointers
    base = wr_log.size();
    for (int i = 0; i < 10; i++) cyc(0, 1, 8'h40 + 8'(i), 32'h60000000 + i);
    cyc(0, 0, 8'h00, 32'h0);
    cyc(0, 0, 8'h00, 32'h0);
    chk("t6_log_n", wr_log.size() - base, 10);
    for (int i = 0; i < 10 && base + i < wr_log.size(); i++)
      chk("t6_order", wr_log[base+i], {8'h40 + 8'(i), 32'h60000000 + i});

    bad_mem = 0;
    for (int i = 0; i < DM_DEPTH; i++)
      if ((mem_v[i] ? mem[i] : init_val(8'(i))) !== (ref_v[i] ? ref_mem[i] : init_val(8'(i))))
        bad_mem++;
    chk("mem_image", bad_mem, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
